full_adder_4bit_cla: RTL and testbench
======================================

Name: full_adder_4bit_cla

Overview:
- 4-bit carry-lookahead adder computing Sum = A + B + Cin with carry-out, group propagate/generate and signed overflow.
- Carries come from explicit lookahead equations, not ripple.
- Combinational CLA core feeding an output register stage, so results are registered one cycle after valid inputs.
- Building block for wider adders: the group P/G outputs feed a second-level lookahead unit.

Parameters:
- WIDTH, 4, operand width; fixed at 4; any other value is unsupported and must trigger an elaboration-time error.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B/Cin are valid this cycle.
- A  input  4  operand A, unsigned or two's complement.
- B  input  4  operand B.
- Cin  input  1  carry-in.
- out_valid  output  1  registered outputs hold a fresh result.
- Sum  output  4  registered sum bits.
- Cout  output  1  registered carry-out (c4).
- PG  output  1  registered group propagate, p3&p2&p1&p0.
- GG  output  1  registered group generate.
- Overflow  output  1  registered signed overflow, c4 ^ c3.

Behaviour:
- Reset is asynchronous and active-low: one clock (clk); asserting rst_n=0 immediately clears every output register.
  - Sum, Cout, PG, GG, Overflow and out_valid all go to 0.
  - Outputs stay 0 while rst_n=0.
  - Release is sampled at the next rising clk.
- Core, all combinational:
  - Bit terms: g_i = A_i & B_i and p_i = A_i ^ B_i, for i = 0..3.
  - c0 = Cin.
  - c1 = g0 | p0c0.
  - c2 = g1 | p1g0 | p1p0c0.
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0.
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0.
  - Sum_i = p_i ^ c_i.
  - GG = g3 | p3g2 | p3p2g1 | p3p2p1g0, which is independent of Cin.
  - PG = p3&p2&p1&p0.
  - Overflow = c4 ^ c3.
- Every carry must be a flat sum-of-products of g/p/c0. No c_i may be derived from c_(i-1).
- Latency: 1 cycle.
  - On a rising edge with in_valid=1, register the core results and set out_valid=1.
  - On a rising edge with in_valid=0, set out_valid=0. Sum, Cout, PG, GG and Overflow hold their previous values.
- Back-to-back valid inputs give one result per cycle. There is no backpressure and no stall.
- Arithmetic: {Cout,Sum} equals the 5-bit unsigned value A+B+Cin, exact for all 512 input combinations.
- Boundary cases:
  - 15+15+0 gives Sum=1110, Cout=1.
  - 15+0+1 gives Sum=0000, Cout=1, PG=1, GG=0.
  - 0+0+0 gives all outputs 0.
- Reset asserted mid-stream: any pending result is discarded; out_valid=0 in the first cycle after release unless in_valid=1 at that edge.
- No X propagation from reset: every output register has a defined reset value.

Test Plan:
- Reset: drive rst_n=0 asynchronously between edges with A=15, B=15, Cin=1, in_valid=1 -> all outputs 0 immediately, and they stay 0 until release.
- Max operands: A=1111, B=1111, Cin=0, in_valid=1 for one edge -> next cycle Sum=1110, Cout=1, GG=1, PG=0, Overflow=0, out_valid=1; the following cycle with in_valid=0 -> out_valid=0, Sum still 1110.
- Full propagate chain: A=1111, B=0000, Cin=1 -> Sum=0000, Cout=1, PG=1, GG=0, Overflow=0.
- Signed overflow: A=0111, B=0001, Cin=0 -> Sum=1000, Cout=0, Overflow=1; A=1000, B=1000 -> Sum=0000, Cout=1, Overflow=1.
- Exhaustive streaming: all 512 {A,B,Cin} combinations back-to-back with in_valid=1 -> each cycle {Cout,Sum} equals A+B+Cin of the previous cycle, and Overflow and PG/GG match the reference equations.
- Mid-stream reset: pulse rst_n low for half a cycle during the exhaustive stream -> outputs clear immediately; results resume with correct 1-cycle latency after release.

Source files
------------

// File: rtl/full_adder_4bit_cla.sv
// 4-bit carry-lookahead adder with group P/G and signed overflow, registered one cycle.
// Carries are flat sum-of-products of bit g/p terms and Cin; no carry feeds another.

module cla_bit_pg (
    input  logic a,
    input  logic b,
    output logic g,
    output logic p
);
    assign g = a & b;
    assign p = a ^ b;
endmodule

module full_adder_4bit_cla #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             PG,
    output logic             GG,
    output logic             Overflow
);

    // The lookahead equations below are written for exactly four bits.
    if (WIDTH != 4) begin : g_bad_width
        $error("full_adder_4bit_cla: WIDTH must be 4");
    end

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cla_bit_pg u_pg (
            .a (A[i]),
            .b (B[i]),
            .g (g[i]),
            .p (p[i])
        );
    end

    logic             c0, c1, c2, c3, c4;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_c;
    logic             gg_c;
    logic             pg_c;

    always_comb begin
        c0 = Cin;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        carry = {c3, c2, c1, c0};
        sum_c = p ^ carry;
        gg_c  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg_c  = &p;
    end

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             pg_q, pg_d;
    logic             gg_q, gg_d;
    logic             ovf_q, ovf_d;

    // Result fields only load on a valid edge; otherwise they hold.
    always_comb begin
        valid_d = in_valid;
        sum_d   = sum_q;
        cout_d  = cout_q;
        pg_d    = pg_q;
        gg_d    = gg_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            sum_d  = sum_c;
            cout_d = c4;
            pg_d   = pg_c;
            gg_d   = gg_c;
            ovf_d  = c4 ^ c3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            pg_q    <= 1'b0;
            gg_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            pg_q    <= pg_d;
            gg_q    <= gg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign PG        = pg_q;
    assign GG        = gg_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_full_adder_4bit_cla.sv
// Directed and exhaustive-stream bench for full_adder_4bit_cla.
// Observed word layout: {out_valid, Overflow, GG, PG, Cout, Sum[3:0]}.

module tb_full_adder_4bit_cla;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A, B;
    logic       Cin;
    logic       out_valid;
    logic [3:0] Sum;
    logic       Cout, PG, GG, Overflow;

    int tests  = 0;
    int failed = 0;

    full_adder_4bit_cla #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .PG        (PG),
        .GG        (GG),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {out_valid, Overflow, GG, PG, Cout, Sum};
    endfunction

    // Reference built from plain integer addition and sign rules.
    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] s, s0;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + {4'b0, c};
        s0  = {1'b0, a} + {1'b0, b};
        ovf = (a[3] == b[3]) && (s[3] != a[3]);
        return {1'b1, ovf, s0[4], &(a ^ b), s[4], s[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = c;
    endtask

    logic [8:0] exp_prev;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        chk("reset_init", obs(), 9'b0);
        rst_n = 1'b1;

        // Load a nonzero result, then reset asynchronously between edges
        drive(1'b1, 4'd15, 4'd15, 1'b1);
        @(posedge clk);
        #2;
        chk("pre_reset_load", obs(), 9'b1_0_1_0_1_1111);
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", obs(), 9'b0);
        @(posedge clk);
        #1;
        chk("reset_held_1", obs(), 9'b0);
        @(posedge clk);
        #1;
        chk("reset_held_2", obs(), 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'd15, 4'd15, 1'b1);
        @(negedge clk);
        chk("release_no_valid", obs(), 9'b0);

        // Max operands then a hold cycle
        drive(1'b1, 4'd15, 4'd15, 1'b0);
        @(negedge clk);
        chk("max_operands", obs(), 9'b1_0_1_0_1_1110);
        drive(1'b0, 4'd3, 4'd4, 1'b0);
        @(negedge clk);
        chk("max_hold", obs(), 9'b0_0_1_0_1_1110);

        drive(1'b1, 4'd15, 4'd0, 1'b1);
        @(negedge clk);
        chk("prop_chain", obs(), 9'b1_0_0_1_1_0000);

        drive(1'b1, 4'd7, 4'd1, 1'b0);
        @(negedge clk);
        chk("ovf_pos", obs(), 9'b1_1_0_0_0_1000);

        drive(1'b1, 4'd8, 4'd8, 1'b0);
        @(negedge clk);
        chk("ovf_neg", obs(), 9'b1_1_1_0_1_0000);

        drive(1'b1, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        chk("zeros", obs(), 9'b1_0_0_0_0_0000);

        // Exhaustive back-to-back stream with a mid-stream reset pulse
        exp_prev = '0;
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (i > 0) chk($sformatf("stream_%0d", i - 1), obs(), exp_prev);
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                chk("midstream_reset_clear", obs(), 9'b0);
                #3;
                rst_n = 1'b1;
            end
            if (i < 512) begin
                drive(1'b1, i[8:5], i[4:1], i[0]);
                exp_prev = model(i[8:5], i[4:1], i[0]);
            end
        end

        drive(1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        chk("stream_end_idle", obs(), {1'b0, exp_prev[7:0]});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
